// File: rtl/key_repeat_pkg.sv
// Shared state encoding and width helpers for the key auto-repeat block.
// Pure definitions: no latency, no backpressure.
package key_repeat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter must hold values up to max(HOLD_T, RATE_T) - 1.
    function automatic int cnt_width(input int hold_t, input int rate_t);
        return $clog2(max_int(hold_t, rate_t) + 1);
    endfunction

endpackage

// File: rtl/key_repeat_if.sv
// Key level inputs and event outputs of the auto-repeat block, one bit per channel.
// Plain wires: no latency, no backpressure.
interface key_repeat_if #(
    parameter int NIN = 2
) ();

    logic [NIN-1:0] i_lvl;
    logic [NIN-1:0] o_press;
    logic [NIN-1:0] o_repeat;
    logic [NIN-1:0] o_release;
    logic [NIN-1:0] o_held;

    modport master (
        output i_lvl,
        input  o_press,
        input  o_repeat,
        input  o_release,
        input  o_held
    );

    modport slave (
        input  i_lvl,
        output o_press,
        output o_repeat,
        output o_release,
        output o_held
    );

endinterface

// File: rtl/key_repeat_chan.sv
// One key channel: IDLE/HOLD/REPEAT FSM turning a level into press/repeat/release pulses.
// Latency 1 clk from sampling edge to pulse; no backpressure, pulses are fire-and-forget.
module key_repeat_chan
    import key_repeat_pkg::*;
#(
    parameter int HOLD_T = 500,
    parameter int RATE_T = 100
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_lvl,
    input  logic i_rise,
    output logic o_press,
    output logic o_repeat,
    output logic o_release,
    output logic o_held
);

    localparam int CW = cnt_width(HOLD_T, RATE_T);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_T - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(RATE_T - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_press;
    logic            r_repeat;
    logic            r_release;
    logic            r_held;
    logic            w_press_nxt;
    logic            w_repeat_nxt;
    logic            w_release_nxt;
    logic            w_held_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_repeat  <= 1'b0;
            r_release <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_repeat  <= w_repeat_nxt;
            r_release <= w_release_nxt;
            r_held    <= w_held_nxt;
        end
    end

    // A low level is checked before the tick so a release always wins over a repeat.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rise) begin
                    w_press_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!i_lvl) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (i_tick) begin
                    if (r_cnt == HOLD_LAST) begin
                        w_repeat_nxt = 1'b1;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_REPEAT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (!i_lvl) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (i_tick) begin
                    if (r_cnt == RATE_LAST) begin
                        w_repeat_nxt = 1'b1;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_held_nxt = (w_state_nxt != ST_IDLE);
    end

    assign o_press   = r_press;
    assign o_repeat  = r_repeat;
    assign o_release = r_release;
    assign o_held    = r_held;

endmodule

// File: rtl/key_repeat.sv
// Typematic key events for NIN debounced levels: shared tick prescaler plus one FSM per channel.
// Latency 1 clk from sampling edge to pulse; no backpressure, pulses are fire-and-forget.
module key_repeat
    import key_repeat_pkg::*;
#(
    parameter int NIN      = 2,
    parameter int TICK_DIV = 50000,
    parameter int HOLD_T   = 500,
    parameter int RATE_T   = 100
) (
    input  logic         i_clk,
    input  logic         i_rst,
    key_repeat_if.slave  kr_bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]  r_presc;
    logic           w_tick;
    logic [NIN-1:0] r_prev;
    logic [NIN-1:0] w_rise;
    logic [NIN-1:0] w_press;
    logic [NIN-1:0] w_repeat;
    logic [NIN-1:0] w_release;
    logic [NIN-1:0] w_held;

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Previous level resets high so a key held through reset must be released first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= '1;
        end else begin
            r_prev <= kr_bus.i_lvl;
        end
    end

    assign w_rise = kr_bus.i_lvl & ~r_prev;

    for (genvar g = 0; g < NIN; g++) begin : g_chan
        key_repeat_chan #(
            .HOLD_T (HOLD_T),
            .RATE_T (RATE_T)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_tick    (w_tick),
            .i_lvl     (kr_bus.i_lvl[g]),
            .i_rise    (w_rise[g]),
            .o_press   (w_press[g]),
            .o_repeat  (w_repeat[g]),
            .o_release (w_release[g]),
            .o_held    (w_held[g])
        );
    end

    assign kr_bus.o_press   = w_press;
    assign kr_bus.o_repeat  = w_repeat;
    assign kr_bus.o_release = w_release;
    assign kr_bus.o_held    = w_held;

endmodule

// File: tb/tb_key_repeat.sv
// Bench for key_repeat with TICK_DIV=4, HOLD_T=3, RATE_T=2 on two channels.
module tb_key_repeat;
    localparam int TDIV = 4;
    localparam int HOLD = 3;
    localparam int RATE = 2;

    typedef struct {
        int         due;
        logic [1:0] p, r, l, h;
    } exp_t;

    typedef struct {
        logic [1:0] lvl, p, r, l, h;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    exp_t q[$];
    exp_t mon_e;
    vec_t tbl[$];

    // reference state: edges since reset, previous level, held flags, ticks since press
    int         en;
    logic [1:0] m_prev;
    logic [1:0] m_held;
    int         m_t[2];

    int last_press = -100;
    int last_rep   = -100;
    int nrep       = 0;

    key_repeat_if #(.NIN(2)) kr_if ();

    key_repeat #(
        .NIN      (2),
        .TICK_DIV (TDIV),
        .HOLD_T   (HOLD),
        .RATE_T   (RATE)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .kr_bus (kr_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, want);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d..%0d", nm, cyc, act, lo, hi);
        end
    endtask

    function automatic vec_t v(input logic [1:0] lvl, p, r, l, h);
        vec_t x;
        x.lvl = lvl; x.p = p; x.r = r; x.l = l; x.h = h;
        return x;
    endfunction

    task automatic model(input logic rs, input logic [1:0] lvl,
                         output logic [1:0] ep, output logic [1:0] er,
                         output logic [1:0] el, output logic [1:0] eh);
        logic tk;
        ep = '0; er = '0; el = '0; eh = '0;
        if (rs) begin
            en = 0;
            m_prev = 2'b11;
            m_held = 2'b00;
        end else begin
            en++;
            tk = (en % TDIV == 0);
            for (int c = 0; c < 2; c++) begin
                if (!m_held[c]) begin
                    if (lvl[c] && !m_prev[c]) begin
                        ep[c] = 1'b1;
                        m_held[c] = 1'b1;
                        m_t[c] = 0;
                    end
                end else if (!lvl[c]) begin
                    el[c] = 1'b1;
                    m_held[c] = 1'b0;
                end else if (tk) begin
                    m_t[c]++;
                    if (m_t[c] == HOLD || (m_t[c] > HOLD && (m_t[c] - HOLD) % RATE == 0))
                        er[c] = 1'b1;
                end
            end
            m_prev = lvl;
            eh = m_held;
        end
    endtask

    task automatic drive(input logic rs, input logic [1:0] lvl,
                         input logic [1:0] ep, input logic [1:0] er,
                         input logic [1:0] el, input logic [1:0] eh);
        exp_t e;
        rst = rs;
        kr_if.i_lvl = lvl;
        e.due = cyc + 1;
        e.p = ep; e.r = er; e.l = el; e.h = eh;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic step(input logic rs, input logic [1:0] lvl);
        logic [1:0] ep, er, el, eh;
        model(rs, lvl, ep, er, el, eh);
        drive(rs, lvl, ep, er, el, eh);
    endtask

    task automatic run_tbl(input int lo, input int hi);
        logic [1:0] ep, er, el, eh;
        for (int i = lo; i <= hi; i++) begin
            model(1'b0, tbl[i].lvl, ep, er, el, eh);
            drive(1'b0, tbl[i].lvl, tbl[i].p, tbl[i].r, tbl[i].l, tbl[i].h);
        end
    endtask

    // Scoreboard: pop the expectation due for the edge just past and compare.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            mon_e = q.pop_front();
            chk_rng("sb_order", mon_e.due, cyc, cyc);
            chk("press",   kr_if.o_press,   mon_e.p);
            chk("repeat",  kr_if.o_repeat,  mon_e.r);
            chk("release", kr_if.o_release, mon_e.l);
            chk("held",    kr_if.o_held,    mon_e.h);
            if (kr_if.o_press[0] === 1'b1) begin
                last_press = cyc;
                nrep = 0;
            end
            if (kr_if.o_repeat[0] === 1'b1) begin
                if (nrep == 0) chk_rng("first_rpt_gap", cyc - last_press, 9, 12);
                else           chk_rng("rpt_gap", cyc - last_rep, 8, 8);
                last_rep = cyc;
                nrep++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // rows 0..5: end of reset test; rows 6..: short press/release and channel independence
        for (int i = 0; i < 5; i++) tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(v(2'b01, 2'b01, 2'b00, 2'b00, 2'b01));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(v(2'b01, 2'b01, 2'b00, 2'b00, 2'b01));
        for (int i = 0; i < 4; i++) tbl.push_back(v(2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(v(2'b10, 2'b10, 2'b00, 2'b00, 2'b10));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b10, 2'b00));
        tbl.push_back(v(2'b01, 2'b01, 2'b00, 2'b00, 2'b01));
        tbl.push_back(v(2'b10, 2'b10, 2'b00, 2'b01, 2'b10));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b10, 2'b00));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

        // 1: keys held through reset give no press
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11);
        for (int i = 0; i < 100; i++) step(1'b0, 2'b11);
        run_tbl(0, 5);

        // 2: hold ch0, typematic repeats
        for (int i = 0; i < 60; i++) step(1'b0, 2'b01);

        // 3: short press released in HOLD, plus independent channel edges
        run_tbl(6, tbl.size() - 1);

        // 4: release on the edge where a REPEAT-state repeat would fire
        step(1'b0, 2'b01);
        for (int i = 0; i < 100; i++) begin
            if (((en + 1) % TDIV == 0) && m_held[0] && (m_t[0] + 1 == HOLD + RATE)) break;
            step(1'b0, 2'b01);
        end
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);

        // 5: both pressed together, ch1 released 10 clk later, ch0 keeps repeating
        step(1'b0, 2'b11);
        for (int i = 0; i < 9; i++) step(1'b0, 2'b11);
        step(1'b0, 2'b01);
        for (int i = 0; i < 30; i++) step(1'b0, 2'b01);
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);

        // 6: reset mid-REPEAT with the key held, then a fresh release/press
        step(1'b0, 2'b01);
        for (int i = 0; i < 20; i++) step(1'b0, 2'b01);
        step(1'b1, 2'b01);
        for (int i = 0; i < 12; i++) step(1'b0, 2'b01);
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);
        step(1'b0, 2'b01);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b01);
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);

        @(negedge clk);
        @(negedge clk);
        chk_rng("queue_drained", q.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
